// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative radix-2 shift-add multiplier.
// One partial product is accumulated per clock, so a product takes SIZE
// cycles in BUSY. Signed operands are reduced to magnitudes on accept, and
// the sign is applied once when the final partial product is added.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands and mode are valid this cycle
//   in_ready   block can accept an operation (IDLE)
//   a          multiplicand, SIZE bits
//   b          multiplier, SIZE bits
//   is_signed  1 = two's-complement operands, 0 = unsigned
//   out_valid  product is valid (DONE)
//   out_ready  consumer accepts the product
//   c          product, 2*SIZE bits
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for in_valid; operands latched on accept
// BUSY  | one shift-add step per edge, SIZE steps in total
// DONE  | product held on c until out_ready
module seq_multiplier #(
    parameter int SIZE = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SIZE-1:0]     a,
    input  logic [SIZE-1:0]     b,
    input  logic                is_signed,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*SIZE-1:0]   c
);

    localparam int PW = 2 * SIZE;
    localparam int CW = $clog2(SIZE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [SIZE-1:0] mcand;
    logic [SIZE-1:0] mplier;
    logic [PW-1:0]   acc;
    logic [CW-1:0]   count;
    logic            neg;

    logic [SIZE-1:0] mag_a;
    logic [SIZE-1:0] mag_b;
    logic [PW-1:0]   partial;
    logic [PW-1:0]   sum;
    logic            last_step;

    // -2^(SIZE-1) negates to itself, which read as unsigned is exactly
    // its magnitude, so no extra bit is needed.
    assign mag_a = (is_signed && a[SIZE-1]) ? ((~a) + SIZE'(1)) : a;
    assign mag_b = (is_signed && b[SIZE-1]) ? ((~b) + SIZE'(1)) : b;

    assign last_step = (count == CW'(SIZE - 1));
    assign partial   = mplier[0] ? (PW'(mcand) << count) : '0;
    assign sum       = acc + partial;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            neg    <= 1'b0;
            c      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand  <= mag_a;
                        mplier <= mag_b;
                        neg    <= is_signed & (a[SIZE-1] ^ b[SIZE-1]);
                        acc    <= '0;
                        count  <= '0;
                    end
                end
                BUSY: begin
                    acc    <= sum;
                    mplier <= mplier >> 1;
                    count  <= count + CW'(1);
                    // c only ever sees a finished product
                    if (last_step) begin
                        c <= neg ? ((~sum) + PW'(1)) : sum;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        iv8, ir8, s8, ov8, or8;
    logic [7:0]  a8, b8;
    logic [15:0] c8;

    logic        iv2, ir2, s2, ov2, or2;
    logic [1:0]  a2, b2;
    logic [3:0]  c2;

    seq_multiplier #(.SIZE(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .is_signed(s8),
        .out_valid(ov8), .out_ready(or8), .c(c8)
    );

    seq_multiplier #(.SIZE(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv2), .in_ready(ir2),
        .a(a2), .b(b2), .is_signed(s2),
        .out_valid(ov2), .out_ready(or2), .c(c2)
    );

    typedef struct {
        logic [15:0] val;
        int          cyc;
    } exp_t;

    exp_t q8[$];
    exp_t q2[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // Reference products: plain integer multiply, truncated to 2*SIZE bits.
    function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic s);
        int ix, iy, p;
        if (s) begin
            ix = $signed(x);
            iy = $signed(y);
        end else begin
            ix = int'(x);
            iy = int'(y);
        end
        p = ix * iy;
        return p[15:0];
    endfunction

    function automatic logic [3:0] ref2(input logic [1:0] x, input logic [1:0] y, input logic s);
        int ix, iy, p;
        if (s) begin
            ix = $signed(x);
            iy = $signed(y);
        end else begin
            ix = int'(x);
            iy = int'(y);
        end
        p = ix * iy;
        return p[3:0];
    endfunction

    // Monitors: pop the scoreboard whenever a DUT presents a new product.
    logic prev8 = 1'b0;
    logic prev2 = 1'b0;
    exp_t e8, e2;

    always @(negedge clk) begin
        if (ov8 && !prev8) begin
            if (q8.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL dut8_unexpected_output: c=%0h, nothing outstanding", c8);
            end else begin
                e8 = q8.pop_front();
                check("dut8_product", 32'(c8), 32'(e8.val));
                check("dut8_latency", 32'(cyc - e8.cyc), 32'd8);
            end
        end
        prev8 = ov8;
    end

    always @(negedge clk) begin
        if (ov2 && !prev2) begin
            if (q2.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL dut2_unexpected_output: c=%0h, nothing outstanding", c2);
            end else begin
                e2 = q2.pop_front();
                check("dut2_product", 32'(c2), 32'(e2.val));
                check("dut2_latency", 32'(cyc - e2.cyc), 32'd2);
            end
        end
        prev2 = ov2;
    end

    // Called just after a rising edge; returns just after the accept edge.
    task automatic issue8(input logic [7:0] x, input logic [7:0] y, input logic s);
        int t;
        exp_t e;
        t = 0;
        while (!ir8 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (!ir8) begin
            fail_now("dut8_in_ready_wait");
            return;
        end
        a8 = x; b8 = y; s8 = s; iv8 = 1'b1;
        e.val = ref8(x, y, s);
        e.cyc = cyc + 1;
        q8.push_back(e);
        @(posedge clk); #1;
        iv8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        s8 = 1'($urandom);
    endtask

    task automatic wait8();
        int t;
        t = 0;
        while (!ov8 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!ov8) begin
            fail_now("dut8_out_valid_wait");
        end else if (or8) begin
            @(posedge clk); #1;
            check("dut8_in_ready_after_handshake", 32'(ir8), 32'd1);
            check("dut8_out_valid_cleared", 32'(ov8), 32'd0);
        end
    endtask

    task automatic issue2(input logic [1:0] x, input logic [1:0] y, input logic s);
        int t;
        exp_t e;
        t = 0;
        while (!ir2 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (!ir2) begin
            fail_now("dut2_in_ready_wait");
            return;
        end
        a2 = x; b2 = y; s2 = s; iv2 = 1'b1;
        e.val = 16'(ref2(x, y, s));
        e.cyc = cyc + 1;
        q2.push_back(e);
        @(posedge clk); #1;
        iv2 = 1'b0;
    endtask

    task automatic wait2();
        int t;
        t = 0;
        while (!ov2 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!ov2) begin
            fail_now("dut2_out_valid_wait");
        end else begin
            @(posedge clk); #1;
            check("dut2_in_ready_after_handshake", 32'(ir2), 32'd1);
        end
    endtask

    logic [7:0] da [10] = '{8'hFF, 8'hFF, 8'hFF, 8'h80, 8'h80, 8'h00, 8'h00, 8'h7F, 8'h80, 8'h01};
    logic [7:0] db [10] = '{8'hFF, 8'h7F, 8'h7F, 8'h80, 8'h01, 8'hA5, 8'hA5, 8'h80, 8'hFF, 8'hFF};
    logic       ds [10] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0};

    initial begin
        int stall;
        logic [15:0] held;

        rst_n = 1'b0;
        iv8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0; s8 = 1'b0;
        iv2 = 1'b0; or2 = 1'b1; a2 = '0; b2 = '0; s2 = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_dut8_in_ready", 32'(ir8), 32'd1);
        check("reset_dut8_out_valid", 32'(ov8), 32'd0);
        check("reset_dut8_c", 32'(c8), 32'd0);
        check("reset_dut2_in_ready", 32'(ir2), 32'd1);
        check("reset_dut2_out_valid", 32'(ov2), 32'd0);
        check("reset_dut2_c", 32'(c2), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // directed corner operands
        for (int i = 0; i < 10; i++) begin
            issue8(da[i], db[i], ds[i]);
            wait8();
        end

        // random operands, mode and output stalls
        for (int i = 0; i < 40; i++) begin
            stall = int'($urandom_range(0, 3));
            or8 = (stall == 0);
            issue8(8'($urandom), 8'($urandom), 1'($urandom));
            wait8();
            if (stall != 0) begin
                repeat (stall) @(posedge clk);
                #1;
                or8 = 1'b1;
                @(posedge clk); #1;
                check("dut8_in_ready_after_stall", 32'(ir8), 32'd1);
            end
        end

        // backpressure: inputs churn while the product is held
        or8 = 1'b0;
        held = 16'hFF81;
        issue8(8'hFF, 8'h7F, 1'b1);
        wait8();
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            iv8 = 1'($urandom);
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            s8 = 1'($urandom);
            @(negedge clk);
            check("bp_c_stable", 32'(c8), 32'(held));
            check("bp_out_valid_held", 32'(ov8), 32'd1);
            check("bp_in_ready_low", 32'(ir8), 32'd0);
        end
        @(posedge clk); #1;
        iv8 = 1'b0;
        or8 = 1'b1;
        @(posedge clk); #1;
        check("bp_release_out_valid", 32'(ov8), 32'd0);
        check("bp_release_in_ready", 32'(ir8), 32'd1);
        repeat (12) @(posedge clk);
        #1;

        // asynchronous reset in the middle of an operation
        issue8(8'hFF, 8'hFF, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midreset_in_ready", 32'(ir8), 32'd1);
        check("midreset_out_valid", 32'(ov8), 32'd0);
        check("midreset_c", 32'(c8), 32'd0);
        q8.delete();
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue8(8'h03, 8'h05, 1'b0);
        wait8();
        check("post_reset_c", 32'(c8), 32'h000F);

        // SIZE=2: every operand pair in both modes
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    issue2(2'(i), 2'(j), 1'(s));
                    wait2();
                end
            end
        end
        issue2(2'd3, 2'd3, 1'b0);
        wait2();
        check("dut2_3x3_unsigned", 32'(c2), 32'h9);
        issue2(2'b10, 2'b10, 1'b1);
        wait2();
        check("dut2_m2xm2_signed", 32'(c2), 32'h4);

        repeat (4) @(posedge clk);
        if (q8.size() != 0 || q2.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d/%0d products never appeared", q8.size(), q2.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d compared so far", n_cmp);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
